// File: rtl/alu_seq.sv
// Sequential N-bit ALU with a valid/ready input handshake, registered y/f and a done pulse.
// MUL uses an iterative shift-add datapath; DIV/MOD use an iterative restoring divider.
module alu_seq #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] y,
    output logic [4:0]   f
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] N_VAL = N'(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [3:0]    op_r;
    logic [N-1:0]  opnd_r;
    logic [N-1:0]  hi_r;
    logic [N-1:0]  lo_r;
    logic [CW-1:0] cnt_r;

    logic          accept;
    logic          iter_op;
    logic [N:0]    add_sum;
    logic [N-1:0]  sc_y;
    logic [4:0]    sc_f;

    // Single-cycle results, including error cases (err set, zero left clear)
    always_comb begin
        accept  = in_valid && in_ready;
        iter_op = (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != '0));
        add_sum = {1'b0, a} + {1'b0, b};
        sc_y    = '0;
        sc_f    = '0;
        case (op)
            OP_ADD: begin
                sc_y    = add_sum[N-1:0];
                sc_f[1] = add_sum[N];
                sc_f[0] = add_sum[N];
            end
            OP_SUB: begin
                sc_y    = (a < b) ? (b - a) : (a - b);
                sc_f[3] = (a < b);
            end
            OP_AND:  sc_y = a & b;
            OP_OR:   sc_y = a | b;
            OP_XOR:  sc_y = a ^ b;
            OP_SHL:  sc_y = (b >= N_VAL) ? '0 : (a << b);
            OP_SHR:  sc_y = (b >= N_VAL) ? '0 : (a >> b);
            default: sc_f[4] = 1'b1;
        endcase
        if (!sc_f[4]) begin
            sc_f[2] = (sc_y == '0);
        end
    end

    logic [N:0]   mul_sum;
    logic [N:0]   div_trial;
    logic [N-1:0] nx_hi;
    logic [N-1:0] nx_lo;
    logic [N-1:0] res_y;
    logic [4:0]   res_f;

    // One iteration: hi/lo hold {product high, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, hi_r} + {1'b0, opnd_r};
        div_trial = {hi_r, lo_r[N-1]} - {1'b0, opnd_r};
        if (op_r == OP_MUL) begin
            if (lo_r[0]) begin
                {nx_hi, nx_lo} = {mul_sum, lo_r[N-1:1]};
            end else begin
                {nx_hi, nx_lo} = {1'b0, hi_r, lo_r[N-1:1]};
            end
        end else if (!div_trial[N]) begin
            nx_hi = div_trial[N-1:0];
            nx_lo = {lo_r[N-2:0], 1'b1};
        end else begin
            nx_hi = {hi_r[N-2:0], lo_r[N-1]};
            nx_lo = {lo_r[N-2:0], 1'b0};
        end

        res_y = '0;
        res_f = '0;
        case (op_r)
            OP_MUL: begin
                res_y    = nx_lo;
                res_f[0] = (nx_hi != '0);
            end
            OP_DIV:  res_y = nx_lo;
            default: res_y = nx_hi;
        endcase
        res_f[2] = (res_y == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_r     <= '0;
            opnd_r   <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            cnt_r    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            y        <= '0;
            f        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (accept) begin
                        op_r <= op;
                        if (iter_op) begin
                            state    <= RUN;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            cnt_r    <= CW'(N);
                            opnd_r   <= (op == OP_MUL) ? a : b;
                            hi_r     <= '0;
                            lo_r     <= (op == OP_MUL) ? b : a;
                        end else begin
                            state <= DONE;
                            y     <= sc_y;
                            f     <= sc_f;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_r  <= nx_hi;
                    lo_r  <= nx_lo;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state    <= DONE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        y        <= res_y;
                        f        <= res_f;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at N=4 and N=8: directed steps plus random ops against an arithmetic model.
module tb_alu_seq;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, MOD = 4'd4;
    localparam logic [3:0] ANDO = 4'd5, ORO = 4'd6, XORO = 4'd7, SHL = 4'd8, SHR = 4'd9;

    logic       clk = 1'b0;
    logic       rst;
    logic       v4, v8, rdy4, rdy8, busy4, busy8, done4, done8;
    logic [3:0] a4, b4, op4, op8, y4;
    logic [7:0] a8, b8, y8;
    logic [4:0] f4, f8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .a(a4), .b(b4), .op(op4),
        .busy(busy4), .done(done4), .y(y4), .f(f4)
    );

    alu_seq #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .a(a8), .b(b8), .op(op8),
        .busy(busy8), .done(done8), .y(y8), .f(f8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int n, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
        if (n == 4) begin
            v4 = v; a4 = a[3:0]; b4 = b[3:0]; op4 = op;
        end else begin
            v8 = v; a8 = a; b8 = b; op8 = op;
        end
    endtask

    function automatic logic [7:0] get_y(input int n);
        return (n == 4) ? {4'b0, y4} : y8;
    endfunction
    function automatic logic [4:0] get_f(input int n);
        return (n == 4) ? f4 : f8;
    endfunction
    function automatic logic get_done(input int n);
        return (n == 4) ? done4 : done8;
    endfunction
    function automatic logic get_rdy(input int n);
        return (n == 4) ? rdy4 : rdy8;
    endfunction
    function automatic logic get_busy(input int n);
        return (n == 4) ? busy4 : busy8;
    endfunction

    // Reference: plain integer arithmetic on the opcode's definition
    function automatic void model(input int n, input logic [7:0] a_in, input logic [7:0] b_in,
                                  input logic [3:0] op, output int unsigned y,
                                  output logic [4:0] f, output int lat);
        int unsigned a, b, m, s;
        logic err, neg, carry, ovf;
        a = a_in; b = b_in; m = 1 << n;
        err = 0; neg = 0; carry = 0; ovf = 0; y = 0; lat = 1;
        case (op)
            ADD: begin s = a + b; y = s % m; carry = (s >= m); ovf = carry; end
            SUB: begin y = (a >= b) ? a - b : b - a; neg = (a < b); end
            MUL: begin s = a * b; y = s % m; ovf = (s >= m); lat = n + 1; end
            DIV: if (b == 0) err = 1; else begin y = a / b; lat = n + 1; end
            MOD: if (b == 0) err = 1; else begin y = a % b; lat = n + 1; end
            ANDO: y = a & b;
            ORO:  y = a | b;
            XORO: y = a ^ b;
            SHL: y = (b >= n) ? 0 : (a << b) % m;
            SHR: y = (b >= n) ? 0 : a >> b;
            default: err = 1;
        endcase
        f = {err, neg, (!err && y == 0), carry, ovf};
    endfunction

    task automatic run_op(input int n, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] op, input string tag);
        int unsigned ey;
        logic [4:0] ef;
        int elat, cyc;
        model(n, a, b, op, ey, ef, elat);
        @(negedge clk);
        cyc = 0;
        while (!get_rdy(n) && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, "_ready"}, 32'(get_rdy(n)), 32'd1);
        drive(n, 1'b1, a, b, op);
        @(posedge clk); #1;
        drive(n, 1'b0, a, b, op);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!get_done(n) && cyc < 50);
        check({tag, "_lat"}, 32'(cyc), 32'(elat));
        check({tag, "_y"}, 32'(get_y(n)), 32'(ey));
        check({tag, "_f"}, 32'(get_f(n)), 32'(ef));
    endtask

    initial begin
        rst = 1'b1;
        drive(4, 1'b0, 8'h0, 8'h0, ADD);
        drive(8, 1'b0, 8'h0, 8'h0, ADD);
        repeat (2) @(negedge clk);
        check("rst_y8", 32'(y8), 32'd0);
        check("rst_f8", 32'(f8), 32'd0);
        check("rst_ctl4", 32'({rdy4, busy4, done4}), 32'd0);
        check("rst_ctl8", 32'({rdy8, busy8, done8}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_rdy4", 32'(rdy4), 32'd1);
        check("rel_rdy8", 32'(rdy8), 32'd1);

        run_op(4, 8'hF, 8'h1, ADD, "add_wrap");
        check("add_wrap_lit", 32'({y4, f4}), 32'({4'b0000, 5'b00111}));
        run_op(4, 8'h3, 8'h1, ADD, "add");
        run_op(4, 8'h1, 8'h2, SUB, "sub_neg");
        check("sub_neg_lit", 32'({y4, f4}), 32'({4'b0001, 5'b01000}));
        run_op(4, 8'h4, 8'h1, SUB, "sub");

        // MUL 15*2 with a stray in_valid and changed operands while busy
        @(negedge clk);
        drive(4, 1'b1, 8'hF, 8'h2, MUL);
        @(posedge clk); #1;
        drive(4, 1'b0, 8'h3, 8'h3, ADD);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("mul_busy", 32'({busy4, rdy4, done4}), 32'(3'b100));
            if (c == 2) drive(4, 1'b1, 8'h1, 8'h1, ADD);
            if (c == 3) drive(4, 1'b0, 8'h1, 8'h1, ADD);
        end
        @(negedge clk);
        check("mul_done", 32'({busy4, rdy4, done4}), 32'(3'b011));
        check("mul_y", 32'(y4), 32'hE);
        check("mul_f", 32'(f4), 32'(5'b00001));
        @(negedge clk);
        check("mul_no_extra", 32'(done4), 32'd0);

        run_op(4, 8'h8, 8'h2, DIV, "div");
        run_op(4, 8'h9, 8'h3, MOD, "mod");
        check("mod_lit", 32'({y4, f4}), 32'({4'b0000, 5'b00100}));
        run_op(4, 8'h8, 8'h0, DIV, "div0");
        check("div0_lit", 32'({y4, f4}), 32'({4'b0000, 5'b10000}));
        run_op(4, 8'h5, 8'h0, MOD, "mod0");
        run_op(4, 8'h5, 8'h3, 4'hC, "illegal");

        // Back-to-back: second op accepted in the DONE cycle of the first
        @(negedge clk);
        drive(8, 1'b1, 8'h01, 8'h03, SHL);
        @(posedge clk); #1;
        drive(8, 1'b0, 8'h01, 8'h03, SHL);
        @(negedge clk);
        check("b2b_done1", 32'({done8, rdy8}), 32'(2'b11));
        check("b2b_y1", 32'(y8), 32'h08);
        check("b2b_f1", 32'(f8), 32'd0);
        drive(8, 1'b1, 8'h80, 8'h09, SHR);
        @(posedge clk); #1;
        drive(8, 1'b0, 8'h80, 8'h09, SHR);
        @(negedge clk);
        check("b2b_done2", 32'(done8), 32'd1);
        check("b2b_y2", 32'(y8), 32'h00);
        check("b2b_f2", 32'(f8), 32'(5'b00100));

        // Reset in the middle of an iterative multiply
        @(negedge clk);
        drive(8, 1'b1, 8'h10, 8'h10, MUL);
        @(posedge clk); #1;
        drive(8, 1'b0, 8'h10, 8'h10, MUL);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("rmul_busy", 32'({busy8, done8}), 32'(2'b10));
        end
        rst = 1'b1;
        #1;
        check("rmul_out", 32'({y8, f8}), 32'd0);
        check("rmul_ctl", 32'({rdy8, busy8, done8}), 32'd0);
        @(negedge clk);
        check("rmul_hold", 32'({rdy8, busy8, done8}), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("rmul_nodone", 32'(done8), 32'd0);
        end
        run_op(8, 8'h7F, 8'h01, ADD, "post_rst_add");
        check("post_rst_lit", 32'({y8, f8}), 32'({8'h80, 5'b00000}));

        for (int i = 0; i < 60; i++) begin
            int n;
            logic [7:0] ra, rb;
            logic [3:0] rop;
            n   = (i % 2 == 0) ? 4 : 8;
            ra  = 8'($urandom % (1 << n));
            rb  = ($urandom_range(0, 5) == 0) ? 8'h0 : 8'($urandom % (1 << n));
            rop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                              : 4'($urandom_range(0, 9));
            run_op(n, ra, rb, rop, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
